// File: rtl/arith_pkg.sv
// Shared constants for the serial arithmetic blocks.
//   ARITH_WIDTH : default operand/result width
//   StIdle/StRun/StDone : FSM state encoding
package arith_pkg;

  localparam int unsigned ARITH_WIDTH = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin.
//   i_a, i_b, i_bin : minuend bit, subtrahend bit, borrow in
//   o_d, o_bout     : difference bit, borrow out
module full_subtractor (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes Diff = A - B - Bin one bit per clock, LSB first.
//   CLK, RST_N       : clock, asynchronous active-low reset
//   Start, Bin, A, B : request and operands, captured together in IDLE
//   Busy             : high while bits are being processed
//   Done             : one-cycle pulse when Diff/Bout/Ovf are updated
//   Diff, Bout, Ovf  : registered difference, borrow out, signed overflow
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = ARITH_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             Start,
  input  logic             Bin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [WIDTH-1:0] r_dsh;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic w_d;
  logic w_br;

  full_subtractor u_fs (
    .i_a    (r_a[0]),
    .i_b    (r_b[0]),
    .i_bin  (r_br),
    .o_d    (w_d),
    .o_bout (w_br)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= StIdle;
      r_a     <= '0;
      r_b     <= '0;
      r_br    <= 1'b0;
      r_dsh   <= '0;
      r_cnt   <= '0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (Start) begin
            r_a     <= A;
            r_b     <= B;
            r_br    <= Bin;
            r_cnt   <= '0;
            r_state <= StRun;
            r_busy  <= 1'b1;
          end
        end
        StRun: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_br  <= w_br;
          // Difference bits enter at the top so bit 0 lands at the LSB after the last step.
          r_dsh <= {w_d, r_dsh[WIDTH-1:1]};
          if (r_cnt == LastStep) begin
            r_cnt   <= '0;
            r_diff  <= {w_d, r_dsh[WIDTH-1:1]};
            r_bout  <= w_br;
            // Shift registers now hold the operand MSBs in bit 0.
            r_ovf   <= (r_a[0] != r_b[0]) && (w_d != r_a[0]);
            r_state <= StDone;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign Diff = r_diff;
  assign Bout = r_bout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST_N = 1'b0;
  logic         Start = 1'b0;
  logic         Bin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         Ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .Start (Start),
    .Bin   (Bin),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Diff  (Diff),
    .Bout  (Bout),
    .Ovf   (Ovf)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: an operation occupies W cycles of Busy then one Done cycle.
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] p_diff = '0;
  logic         p_bout = 1'b0;
  logic         p_ovf = 1'b0;

  function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic bin, output logic [W-1:0] d,
                                  output logic bo, output logic ov);
    int ai = int'(a);
    int bi = int'(b);
    int r = ai - bi - int'(bin);
    d  = W'(r);
    bo = (ai < bi + int'(bin));
    ov = (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  function automatic void model_reset();
    m_left = 0;
    m_done = 1'b0;
    m_diff = '0;
    m_bout = 1'b0;
    m_ovf  = 1'b0;
  endfunction

  function automatic void model_update();
    if (!RST_N) begin
      model_reset();
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_diff = p_diff;
        m_bout = p_bout;
        m_ovf  = p_ovf;
      end
    end else if (Start) begin
      ref_sub(A, B, Bin, p_diff, p_bout, p_ovf);
      m_left = W;
    end
  endfunction

  task automatic check(input string name);
    logic eb;
    eb = (m_left > 0);
    total++;
    if (Busy !== eb || Done !== m_done || Diff !== m_diff || Bout !== m_bout ||
        Ovf !== m_ovf) begin
      bad++;
      $display("FAIL %s cyc=%0d got busy=%b done=%b diff=%h bout=%b ovf=%b want busy=%b done=%b diff=%h bout=%b ovf=%b",
               name, cyc, Busy, Done, Diff, Bout, Ovf, eb, m_done, m_diff, m_bout, m_ovf);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    cyc++;
    model_update();
    @(negedge CLK);
    check("cycle");
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_left > 0 || m_done) && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic bin, input logic [W-1:0] ed, input logic eb,
                          input logic eo);
    int n = 0;
    wait_idle();
    Start = 1'b1; A = a; B = b; Bin = bin;
    step();
    Start = 1'b0; A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    while (!Done && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n != W || Diff !== ed || Bout !== eb || Ovf !== eo ||
        p_diff !== ed || p_bout !== eb || p_ovf !== eo) begin
      bad++;
      $display("FAIL %s got lat=%0d diff=%h bout=%b ovf=%b model=%h/%b/%b want lat=%0d diff=%h bout=%b ovf=%b",
               name, n, Diff, Bout, Ovf, p_diff, p_bout, p_ovf, W, ed, eb, eo);
    end
  endtask

  initial begin
    int last_done;
    int n;
    #1;
    check("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    step();

    directed("a10_b01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);
    directed("a00_b01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    directed("a80_b01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    directed("a05_b05_bin", 8'h05, 8'h05, 1'b1, 8'hFF, 1'b1, 1'b0);
    directed("a7f_bff", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Abort in the 4th RUN cycle while Start keeps pulsing.
    wait_idle();
    Start = 1'b1; A = 8'h33; B = 8'h11; Bin = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      Start = i[0];
      step();
    end
    Start = 1'b0;
    #2 RST_N = 1'b0;
    #1 model_reset();
    check("async_reset");
    step();
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // Start held high: one operation every W+2 cycles.
    Start = 1'b1;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    last_done = -1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (Done) begin
        if (last_done >= 0) begin
          total++;
          if (cyc - last_done != W + 2) begin
            bad++;
            $display("FAIL done_period got=%0d want=%0d", cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
        n++;
        A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      end
    end
    total++;
    if (n < 5) begin
      bad++;
      $display("FAIL done_count got=%0d want>=5", n);
    end
    Start = 1'b0;

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      Start = ($urandom_range(0, 3) == 0);
      A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
      RST_N = ($urandom_range(0, 199) != 0);
      step();
    end
    RST_N = 1'b1;
    Start = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port CLK  input  1: sole clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N  input  1: reset, asynchronous assert, active-low.
REQ-004 SHALL have port Start  input  1: request; sampled only in IDLE.
REQ-005 SHALL have port Bin  input  1: borrow-in, captured with Start.
REQ-006 SHALL have port A  input  WIDTH: minuend, captured with Start.
REQ-007 SHALL have port B  input  WIDTH: subtrahend, captured with Start.
REQ-008 SHALL have port Busy  output  1: high while in RUN.
REQ-009 SHALL have port Done  output  1: one-cycle pulse, result valid.
REQ-010 SHALL have port Diff  output  WIDTH: registered difference.
REQ-011 SHALL have port Bout  output  1: registered borrow-out.
REQ-012 SHALL have port Ovf  output  1: registered signed (two's-complement) overflow flag.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on Start=1; RUN->DONE after WIDTH bit-steps; DONE->IDLE unconditionally next edge.
REQ-014 SHALL, on the accepting edge (edge k), register A, B, Bin into internal shift/borrow registers and clear the bit counter; A/B/Bin changes after edge k have no effect.
REQ-015 SHALL process one bit per edge, LSB first, on edges k+1..k+WIDTH, via d = a ^ b ^ br, br' = (~a & b) | (~(a ^ b) & br).
REQ-016 SHALL, at edge k+WIDTH, load Diff, Bout, Ovf and enter DONE; Done=1 for exactly the cycle following edge k+WIDTH.
REQ-017 SHALL produce Diff = (A - B - Bin) mod 2^WIDTH; Bout = 1 iff unsigned A < B + Bin.
REQ-018 SHALL set Ovf = (A[msb] != B[msb]) && (Diff[msb] != A[msb]).
REQ-019 SHALL ignore Start in RUN and DONE; Start held high continuously yields one operation every WIDTH+2 cycles.
REQ-020 SHALL hold Diff, Bout, Ovf stable from Done until the next completion; they are not cleared on Start.
REQ-021 SHALL drive Busy=1 only in RUN and Done=1 only in DONE; never both.
REQ-022 SHALL keep bit counter width clog2(WIDTH+1); counter saturates/clears, never wraps into a spurious extra step.

Reset
REQ-023 SHALL, on RST_N=0, immediately force IDLE and Busy=0, Done=0, Diff=0, Bout=0, Ovf=0, counter=0, shift registers=0.
REQ-024 SHALL, on reset mid-RUN or in DONE, abort with no Done pulse and no partial result visible.
REQ-025 SHALL accept Start no earlier than the first rising edge after RST_N deasserts.

Structure
REQ-026 SHALL place state encoding (IDLE/RUN/DONE) and WIDTH default constant in shared package arith_pkg.
REQ-027 SHALL instantiate one combinational sub-module full_subtractor (a, b, bin -> d, bout) for the bit-step.
REQ-028 SHALL register every output; no combinational path from inputs to outputs.

Verification
REQ-029 SHALL cover A=0x10, B=0x01, Bin=0 -> Diff=0x0F, Bout=0, Ovf=0; Done high in cycle after edge k+8.
REQ-030 SHALL cover A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1, Ovf=0.
REQ-031 SHALL cover A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0, Ovf=1.
REQ-032 SHALL cover A=0x05, B=0x05, Bin=1 -> Diff=0xFF, Bout=1, Ovf=0.
REQ-033 SHALL cover RST_N low at 4th RUN cycle -> all outputs 0 at once, no Done; Start pulses during RUN ignored.
REQ-034 SHALL cover Start held high, operands changed each op -> Done every 10 cycles, Diff holds prior value until each Done.
